// File: rtl/relu_maxpool.sv
// ReLU + 2x2/2 max pooling + requantisation over NOK parallel conv channels.
// One half-row line buffer of partial maxima per channel; shared raster counters.

module relu_maxpool_lane #(
  parameter int N     = 7,
  parameter int MAXW  = 28,
  parameter int SHIFT = 4,
  parameter int LBW   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap,
  input  logic                  lb_we,
  input  logic                  emit,
  input  logic [LBW-1:0]        lb_idx,
  input  logic signed [2*N+1:0] sample,
  output logic [N:0]            out_data
);
  localparam int IW = 2*N+2;
  localparam logic [IW-1:0] OMAX = IW'((1 << (N+1)) - 1);

  logic signed [IW-1:0] pair;
  logic signed [IW-1:0] lbuf [MAXW/2];
  logic signed [IW-1:0] pm, lb_rd, m;
  logic [IW-1:0]        r, q;
  logic [N:0]           qsat;

  always_comb begin
    lb_rd = lbuf[lb_idx];
    pm    = (sample > pair) ? sample : pair;
    m     = (lb_rd > pm) ? lb_rd : pm;
    r     = m[IW-1] ? '0 : m;
    q     = r >> SHIFT;
    qsat  = (q > OMAX) ? OMAX[N:0] : q[N:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pair     <= '0;
      out_data <= '0;
    end else begin
      if (cap)  pair     <= sample;
      if (emit) out_data <= qsat;
    end
  end

  // Line buffer is not reset; every entry is written on an even row before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) lbuf[lb_idx] <= pm;
  end
endmodule

module relu_maxpool #(
  parameter int N     = 7,
  parameter int NOK   = 3,
  parameter int MAXW  = 28,
  parameter int SHIFT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [NOK-1:0][2*N+1:0]       in_data,
  input  logic [11:0]                   row_len,
  output logic                          out_valid,
  output logic [NOK-1:0][N:0]           out_data,
  output logic [11:0]                   out_row,
  output logic [11:0]                   out_col,
  output logic                          frame_done
);
  localparam int LBW = $clog2(MAXW/2);
  localparam logic [11:0] LBN = 12'(MAXW/2);

  logic [11:0] col, row, w_lat, w_eff;
  logic        started, acc, last_col, last_px, lb_ok;
  logic [1:0]  vld_pipe;
  logic [LBW-1:0] lb_idx;

  always_comb begin
    w_eff       = started ? w_lat : row_len;
    acc         = in_valid && !frame_done;
    last_col    = (col == w_eff - 12'd1);
    last_px     = last_col && (row == w_eff - 12'd1);
    lb_ok       = ({1'b0, col[11:1]} < LBN);
    lb_idx      = col[LBW:1];
    vld_pipe[0] = acc && col[0] && row[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col         <= '0;
      row         <= '0;
      w_lat       <= '0;
      started     <= 1'b0;
      frame_done  <= 1'b0;
      vld_pipe[1] <= 1'b0;
      out_row     <= '0;
      out_col     <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (acc) begin
        started <= 1'b1;
        if (!started) w_lat <= row_len;
        if (last_col) begin
          col <= '0;
          row <= row + 12'd1;
        end else begin
          col <= col + 12'd1;
        end
        if (last_px) frame_done <= 1'b1;
      end
      if (vld_pipe[0]) begin
        out_row <= row >> 1;
        out_col <= col >> 1;
      end
    end
  end

  assign out_valid = vld_pipe[1];

  for (genvar g = 0; g < NOK; g++) begin : g_lane
    relu_maxpool_lane #(.N(N), .MAXW(MAXW), .SHIFT(SHIFT), .LBW(LBW)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .cap      (acc && !col[0]),
      .lb_we    (acc && col[0] && !row[0] && lb_ok),
      .emit     (vld_pipe[0]),
      .lb_idx   (lb_idx),
      .sample   (in_data[g]),
      .out_data (out_data[g])
    );
  end
endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: hand-computed pooled values, indices, latency and frame_done.

module tb_relu_maxpool;
  localparam int N = 7, NOK = 3;

  logic                    clk = 0, reset = 0, in_valid = 0;
  logic [NOK-1:0][2*N+1:0] in_data = '0;
  logic [11:0]             row_len = 12'd4;
  logic                    out_valid, frame_done;
  logic [NOK-1:0][N:0]     out_data;
  logic [11:0]             out_row, out_col;

  int n_chk = 0, n_pass = 0;
  int exp0 [4], exp1 [4], exp2 [4];
  logic signed [15:0] dv [4];

  relu_maxpool #(.N(N), .NOK(NOK), .MAXW(28), .SHIFT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .row_len(row_len),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic feed(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] c);
    @(negedge clk);
    in_valid = 1; in_data[0] = a; in_data[1] = b; in_data[2] = c;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk("rst_vld",  32'(out_valid),  0);
    chk("rst_data", 32'(out_data),   0);
    chk("rst_row",  32'(out_row),    0);
    chk("rst_col",  32'(out_col),    0);
    chk("rst_done", 32'(frame_done), 0);
    @(negedge clk); reset = 1;
  endtask

  // mode 0: ch0=ch1=16*(w*r+c), ch2=0; mode 1: all -100; mode 2: all channels dv[] (W=2)
  task automatic run_frame(input int w, input int mode, input bit gaps);
    int k = 0;
    logic signed [15:0] a, b, c;
    logic [7:0] last0 = 0;
    row_len = 12'(w);
    for (int r = 0; r < w; r++) begin
      for (int cc = 0; cc < w; cc++) begin
        bit win;
        case (mode)
          0:       begin a = 16'(16*(w*r+cc)); b = a; c = 0; end
          1:       begin a = -16'sd100; b = a; c = a; end
          default: begin a = dv[r*2+cc]; b = a; c = a; end
        endcase
        feed(a, b, c);
        if (r == 0 && cc == 0) row_len = 12'd3;   // must be ignored mid-frame
        win = (r % 2 == 1) && (cc % 2 == 1);
        chk("vld", 32'(out_valid), 32'(win));
        chk("done", 32'(frame_done), 32'((r == w-1) && (cc == w-1)));
        if (win) begin
          chk("row", 32'(out_row), 32'(r/2));
          chk("col", 32'(out_col), 32'(cc/2));
          chk("d0", 32'(out_data[0]), 32'(exp0[k]));
          chk("d1", 32'(out_data[1]), 32'(exp1[k]));
          chk("d2", 32'(out_data[2]), 32'(exp2[k]));
          last0 = 8'(exp0[k]);
          k++;
        end
        if (gaps) begin
          int n = $urandom_range(0, 3);
          repeat (n) begin
            idle();
            chk("gap_vld", 32'(out_valid), 0);
            chk("gap_hold", 32'(out_data[0]), 32'(last0));
          end
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // scenario 1: ramp, W=4
    exp0 = '{5, 7, 13, 15}; exp1 = exp0; exp2 = '{0, 0, 0, 0};
    run_frame(4, 0, 0);
    feed(16'sd1000, 16'sd1000, 16'sd1000);
    chk("ign_vld",  32'(out_valid),   0);
    chk("ign_done", 32'(frame_done),  1);
    chk("ign_hold", 32'(out_data[0]), 15);

    // scenario 2: all negative -> ReLU zero
    do_reset();
    exp0 = '{0, 0, 0, 0}; exp1 = exp0; exp2 = exp0;
    run_frame(4, 1, 0);

    // scenario 3: W=2 saturation, then row-0 max through line buffer
    do_reset();
    dv = '{-16'sd3, 16'sd5000, 16'sd0, -16'sd3};
    exp0 = '{255, 0, 0, 0}; exp1 = exp0; exp2 = exp0;
    run_frame(2, 2, 0);
    do_reset();
    dv = '{16'sd47, 16'sd10, -16'sd5, 16'sd3};
    exp0 = '{2, 0, 0, 0}; exp1 = exp0; exp2 = exp0;
    run_frame(2, 2, 0);

    // scenario 4: odd W=5, floor pooling
    do_reset();
    exp0 = '{6, 8, 16, 18}; exp1 = exp0; exp2 = '{0, 0, 0, 0};
    run_frame(5, 0, 0);

    // scenario 5: scenario 1 with random stalls
    do_reset();
    exp0 = '{5, 7, 13, 15}; exp1 = exp0; exp2 = '{0, 0, 0, 0};
    run_frame(4, 0, 1);

    // scenario 6: abort after 6 inputs, then a clean frame
    do_reset();
    row_len = 12'd4;
    for (int i = 0; i < 6; i++) feed(16'(16*i + ((i >= 4) ? 48 : 0)), 16'sd0, 16'sd0);
    chk("pre_abort_vld", 32'(out_valid), 1);
    do_reset();
    run_frame(4, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
